// File: rtl/motoro3_pwm_capture.sv
// PWM feedback capture: synchronizes and de-glitches the gate-sense pin, then measures
// high time and period, and flags duty mismatch and a gate stuck high or low.
module motoro3_pwm_capture #(
    parameter int unsigned FILT_LEN = 2,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m3r_capEn,
    input  logic        pwmIn,
    input  logic [11:0] m3r_pwmLenWant,
    input  logic [11:0] m3r_capTol,
    output logic [11:0] m3c_pwmHigh,
    output logic [12:0] m3c_pwmPeriod,
    output logic        m3c_capValid,
    output logic        m3c_dutyErr,
    output logic        m3c_stuckHigh,
    output logic        m3c_stuckLow,
    output logic        m3c_pwmLevel
);

    localparam int unsigned CW = 12;
    localparam int unsigned PW = 13;
    localparam int unsigned FW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic [FW-1:0]  filt_cnt_q, filt_cnt_d;
    logic           level_q, level_d;
    logic           level_dly_q, level_dly_d;
    logic [CW-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CW-1:0]  lo_cnt_q, lo_cnt_d;
    logic [CW-1:0]  to_cnt_q, to_cnt_d;
    logic [CW-1:0]  pwm_high_q, pwm_high_d;
    logic [PW-1:0]  pwm_period_q, pwm_period_d;
    logic           cap_valid_q, cap_valid_d;
    logic           duty_err_q, duty_err_d;
    logic           stuck_high_q, stuck_high_d;
    logic           stuck_low_q, stuck_low_d;

    logic           rise_c;
    logic           fall_c;
    logic           timeout_c;
    logic [CW-1:0]  diff_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Next-state, counters and result registers
    always_comb begin
        state_d      = state_q;
        sync1_d      = pwmIn;
        sync2_d      = sync1_q;
        filt_cnt_d   = '0;
        level_d      = level_q;
        level_dly_d  = level_q;
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        pwm_high_d   = pwm_high_q;
        pwm_period_d = pwm_period_q;
        cap_valid_d  = 1'b0;
        duty_err_d   = duty_err_q;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        // Level only flips after FILT_LEN consecutive disagreeing samples
        if (sync2_q != level_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                level_d = ~level_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end

        rise_c    = level_q & ~level_dly_q;
        fall_c    = ~level_q & level_dly_q;
        to_cnt_d  = (rise_c | fall_c) ? CW'(1) : sat_inc(to_cnt_q);
        timeout_c = !(rise_c | fall_c) && (to_cnt_d >= CW'(TIMEOUT));

        diff_c = (pwm_high_q >= m3r_pwmLenWant) ? (pwm_high_q - m3r_pwmLenWant)
                                                : (m3r_pwmLenWant - pwm_high_q);
        if (cap_valid_q) begin
            duty_err_d = (diff_c > m3r_capTol);
        end

        if (!m3r_capEn) begin
            state_d  = S_IDLE;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
            to_cnt_d = '0;
        end else if (timeout_c) begin
            state_d  = S_IDLE;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
            if (level_q) begin
                stuck_high_d = 1'b1;
            end else begin
                stuck_low_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise_c) begin
                        state_d  = S_HIGH;
                        hi_cnt_d = CW'(1);
                        lo_cnt_d = '0;
                    end
                end
                S_HIGH: begin
                    if (fall_c) begin
                        state_d  = S_LOW;
                        lo_cnt_d = CW'(1);
                    end else begin
                        hi_cnt_d = sat_inc(hi_cnt_q);
                    end
                end
                S_LOW: begin
                    if (rise_c) begin
                        // Each rise closes the running period and opens the next one
                        pwm_high_d   = hi_cnt_q;
                        pwm_period_d = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
                        cap_valid_d  = 1'b1;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                        state_d      = S_HIGH;
                        hi_cnt_d     = CW'(1);
                        lo_cnt_d     = '0;
                    end else begin
                        lo_cnt_d = sat_inc(lo_cnt_q);
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    hi_cnt_d = '0;
                    lo_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            filt_cnt_q   <= '0;
            level_q      <= 1'b0;
            level_dly_q  <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            to_cnt_q     <= '0;
            pwm_high_q   <= '0;
            pwm_period_q <= '0;
            cap_valid_q  <= 1'b0;
            duty_err_q   <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            filt_cnt_q   <= filt_cnt_d;
            level_q      <= level_d;
            level_dly_q  <= level_dly_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            to_cnt_q     <= to_cnt_d;
            pwm_high_q   <= pwm_high_d;
            pwm_period_q <= pwm_period_d;
            cap_valid_q  <= cap_valid_d;
            duty_err_q   <= duty_err_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign m3c_pwmHigh   = pwm_high_q;
    assign m3c_pwmPeriod = pwm_period_q;
    assign m3c_capValid  = cap_valid_q;
    assign m3c_dutyErr   = duty_err_q;
    assign m3c_stuckHigh = stuck_high_q;
    assign m3c_stuckLow  = stuck_low_q;
    assign m3c_pwmLevel  = level_q;

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Directed bench for motoro3_pwm_capture: capture timing, duty check, glitch rejection,
// stuck detection, enable abort and mid-measurement reset.
module tb_motoro3_pwm_capture;

    logic        clk;
    logic        rst;
    logic        m3r_capEn;
    logic        pwmIn;
    logic [11:0] m3r_pwmLenWant;
    logic [11:0] m3r_capTol;
    logic [11:0] m3c_pwmHigh;
    logic [12:0] m3c_pwmPeriod;
    logic        m3c_capValid;
    logic        m3c_dutyErr;
    logic        m3c_stuckHigh;
    logic        m3c_stuckLow;
    logic        m3c_pwmLevel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cap_cnt  = 0;
    int consec   = 0;
    int cap_cyc[$];
    int rise_cyc[$];
    logic prev_valid = 1'b0;
    logic prev_level = 1'b0;

    motoro3_pwm_capture #(.FILT_LEN(2), .TIMEOUT(4095)) dut (
        .clk            (clk),
        .rst            (rst),
        .m3r_capEn      (m3r_capEn),
        .pwmIn          (pwmIn),
        .m3r_pwmLenWant (m3r_pwmLenWant),
        .m3r_capTol     (m3r_capTol),
        .m3c_pwmHigh    (m3c_pwmHigh),
        .m3c_pwmPeriod  (m3c_pwmPeriod),
        .m3c_capValid   (m3c_capValid),
        .m3c_dutyErr    (m3c_dutyErr),
        .m3c_stuckHigh  (m3c_stuckHigh),
        .m3c_stuckLow   (m3c_stuckLow),
        .m3c_pwmLevel   (m3c_pwmLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log capture pulses and filtered rising edges, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m3c_capValid) begin
            cap_cnt = cap_cnt + 1;
            cap_cyc.push_back(cyc);
            if (prev_valid) consec = consec + 1;
        end
        if (m3c_pwmLevel && !prev_level) rise_cyc.push_back(cyc);
        prev_valid = m3c_capValid;
        prev_level = m3c_pwmLevel;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        pwmIn = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_high"},   32'(m3c_pwmHigh),   32'd0);
        chk({tag, "_period"}, 32'(m3c_pwmPeriod), 32'd0);
        chk({tag, "_valid"},  32'(m3c_capValid),  32'd0);
        chk({tag, "_err"},    32'(m3c_dutyErr),   32'd0);
        chk({tag, "_stkhi"},  32'(m3c_stuckHigh), 32'd0);
        chk({tag, "_stklo"},  32'(m3c_stuckLow),  32'd0);
        chk({tag, "_level"},  32'(m3c_pwmLevel),  32'd0);
    endtask

    initial begin
        int snap;
        int w;
        rst            = 1'b1;
        m3r_capEn      = 1'b1;
        pwmIn          = 1'b0;
        m3r_pwmLenWant = 12'd32;
        m3r_capTol     = 12'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        drive(1'b0, 5);

        // Nominal 32/480 waveform
        cap_cyc.delete();
        rise_cyc.delete();
        repeat (4) pulse(32, 480);
        chk("nom_caps", 32'(cap_cnt), 32'd3);
        chk("nom_high", 32'(m3c_pwmHigh), 32'd32);
        chk("nom_period", 32'(m3c_pwmPeriod), 32'd512);
        chk("nom_first_lat", 32'(cap_cyc[0] - rise_cyc[0]), 32'd513);
        chk("nom_spacing", 32'(cap_cyc[1] - cap_cyc[0]), 32'd512);
        chk("nom_spacing2", 32'(cap_cyc[2] - cap_cyc[1]), 32'd512);
        chk("nom_dutyerr", 32'(m3c_dutyErr), 32'd0);

        // Duty tolerance: |32-40|=8 > 4, then |37-40|=3 <= 4
        m3r_pwmLenWant = 12'd40;
        m3r_capTol     = 12'd4;
        repeat (2) pulse(32, 480);
        chk("duty_err_set", 32'(m3c_dutyErr), 32'd1);
        pulse(37, 475);
        pulse(32, 480);
        chk("duty_high37", 32'(m3c_pwmHigh), 32'd37);
        chk("duty_err_clr", 32'(m3c_dutyErr), 32'd0);

        // 1-cycle low glitch inside a 100-cycle high
        drive(1'b1, 50);
        drive(1'b0, 1);
        drive(1'b1, 3);
        chk("glitch_level", 32'(m3c_pwmLevel), 32'd1);
        drive(1'b1, 46);
        drive(1'b0, 412);
        snap = cap_cnt;
        pulse(20, 492);
        chk("glitch_caps", 32'(cap_cnt - snap), 32'd1);
        chk("glitch_high", 32'(m3c_pwmHigh), 32'd100);
        chk("glitch_period", 32'(m3c_pwmPeriod), 32'd512);

        // Enable dropped mid-HIGH: aborted period must not capture
        drive(1'b1, 10);
        chk("abort_prev_high", 32'(m3c_pwmHigh), 32'd20);
        snap = cap_cnt;
        m3r_capEn = 1'b0;
        drive(1'b1, 5);
        m3r_capEn = 1'b1;
        drive(1'b1, 17);
        drive(1'b0, 480);
        pulse(32, 480);
        chk("abort_nocap", 32'(cap_cnt - snap), 32'd0);
        chk("abort_hold_high", 32'(m3c_pwmHigh), 32'd20);
        chk("abort_hold_period", 32'(m3c_pwmPeriod), 32'd512);
        pulse(32, 480);
        chk("abort_recap", 32'(cap_cnt - snap), 32'd1);
        chk("abort_high", 32'(m3c_pwmHigh), 32'd32);
        chk("abort_period", 32'(m3c_pwmPeriod), 32'd512);

        // Stuck high: flag exactly 4095 cycles after the filtered rise
        pwmIn = 1'b1;
        w = 0;
        while (m3c_pwmLevel !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("stuck_rise_seen", 32'(w < 20), 32'd1);
        repeat (5) @(negedge clk);
        snap = cap_cnt;
        repeat (4089) @(negedge clk);
        chk("stuck_before", 32'(m3c_stuckHigh), 32'd0);
        @(negedge clk);
        chk("stuck_at", 32'(m3c_stuckHigh), 32'd1);
        chk("stuck_nocap", 32'(cap_cnt - snap), 32'd0);
        drive(1'b1, 880);
        chk("stuck_hold", 32'(m3c_stuckHigh), 32'd1);
        chk("stuck_low_clear", 32'(m3c_stuckLow), 32'd0);
        drive(1'b0, 480);
        pulse(32, 480);
        chk("stuck_first_rise", 32'(m3c_stuckHigh), 32'd1);
        chk("stuck_first_nocap", 32'(cap_cnt - snap), 32'd0);
        pulse(32, 480);
        chk("stuck_recap", 32'(cap_cnt - snap), 32'd1);
        chk("stuck_cleared", 32'(m3c_stuckHigh), 32'd0);
        chk("stuck_high_val", 32'(m3c_pwmHigh), 32'd32);

        // One-cycle reset mid-LOW
        drive(1'b1, 32);
        drive(1'b0, 200);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        drive(1'b0, 279);
        snap = cap_cnt;
        pulse(32, 480);
        chk("midrst_nocap", 32'(cap_cnt - snap), 32'd0);
        pulse(32, 480);
        chk("midrst_recap", 32'(cap_cnt - snap), 32'd1);
        chk("midrst_high", 32'(m3c_pwmHigh), 32'd32);
        chk("midrst_period", 32'(m3c_pwmPeriod), 32'd512);

        chk("no_back_to_back", 32'(consec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motoro3_pwm_capture.md
Name: motoro3_pwm_capture

Overview:
- Measures a PWM waveform fed back from the MOS gate-drive sense pin: high time, period, filtered level.
- Counterpart of the PWM generator; closes the loop on the generator's programmed on-time m3r_pwmLenWant.
- Flags duty mismatch against a tolerance and reports a gate stuck high or stuck low.
- Runs at 10 MHz; all counts are in 0.1 us ticks. Results go to the register/status block.

Parameters:
FILT_LEN, 2, consecutive stable synced samples needed before a level change is accepted (1..15)
TIMEOUT, 4095, cycles in one level before a stuck flag is raised (max 4095)

Ports:
clk  in  1  10 MHz clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
m3r_capEn  in  1  capture enable; 0 forces IDLE and aborts any measurement
pwmIn  in  1  asynchronous PWM sense input
m3r_pwmLenWant  in  12  expected high time in ticks
m3r_capTol  in  12  allowed |high - want| in ticks
m3c_pwmHigh  out  12  last captured high time
m3c_pwmPeriod  out  13  last captured period (high + low)
m3c_capValid  out  1  one-cycle pulse when High/Period update
m3c_dutyErr  out  1  mismatch flag for last capture
m3c_stuckHigh  out  1  sticky: input held high >= TIMEOUT
m3c_stuckLow  out  1  sticky: input held low >= TIMEOUT
m3c_pwmLevel  out  1  filtered input level

Behaviour:
- Reset (rst=1 at a clk edge) clears every output, both sync flops, the filter, the counters, and sets state to IDLE. Applies mid-measurement too; no capValid follows.
- Input path: 2-flop synchronizer, then glitch filter.
  - Filter counter increments while synced value != m3c_pwmLevel; clears otherwise.
  - When the count reaches FILT_LEN, m3c_pwmLevel toggles and the counter clears.
  - Pin-to-level latency is 2+FILT_LEN cycles on both edges, so widths are preserved. Pulses shorter than FILT_LEN cycles are discarded.
- Edges: rise/fall are single-cycle strobes on the m3c_pwmLevel transition, registered as level vs. its one-cycle delay.
- States: IDLE, HIGH, LOW.
  - IDLE: wait for rise, then go to HIGH with hiCnt=1.
  - HIGH: hiCnt increments each cycle, saturating at 4095. On fall go to LOW with loCnt=1.
  - LOW: loCnt increments each cycle, saturating.
  - rise in LOW: m3c_pwmHigh<=hiCnt, m3c_pwmPeriod<=hiCnt+loCnt (13-bit, no overflow), m3c_capValid=1 next cycle, both stuck flags cleared, then HIGH with hiCnt=1. Captures are back-to-back: each rise both closes one period and opens the next.
- First rise after IDLE only opens a measurement; the first capValid comes one full period later.
- Timeout: a separate idle/level counter runs in every state, reloads on any edge, saturates.
  - On reaching TIMEOUT: set m3c_stuckHigh if level=1, else m3c_stuckLow; go to IDLE; no capture.
  - An edge in the same cycle as timeout wins: the edge is processed, no flag.
- m3c_dutyErr updates in the capValid cycle: 1 iff |captured high - m3r_pwmLenWant| > m3r_capTol (12-bit unsigned absolute difference). m3r_pwmLenWant is sampled at that same cycle.
- m3r_capEn=0: state IDLE, counters cleared, synchronizer/filter keep running. Captured outputs and flags hold; capValid=0.
- Outputs hold between captures. capValid never asserts on two consecutive cycles.

Test Plan:
- Reset, FILT_LEN=2, capEn=1, pwmIn 32 high / 480 low repeated -> first capValid one period after first rise. Then pwmHigh=32, pwmPeriod=512, pulses every 512 cycles.
- pwmLenWant=40, capTol=4, high 32 / low 480 -> dutyErr=1. Change high to 37 -> dutyErr=0 at next capture.
- 1-cycle low glitch inside a 100-cycle high (FILT_LEN=2) -> m3c_pwmLevel unchanged, pwmHigh=100, period unaffected.
- pwmIn held high 5000 cycles after a rise, TIMEOUT=4095 -> stuckHigh=1 exactly 4095 cycles after the rise is seen, state IDLE, no capValid. Restart 32/480 -> second subsequent rise gives capValid and clears stuckHigh.
- capEn dropped mid-HIGH then restored -> no capValid for the aborted period, outputs hold old values, next full period captured correctly.
- rst asserted for 1 cycle mid-LOW -> all outputs 0 next cycle, first capture only after a fresh rise plus a full period.
